// File: rtl/ram_loader.sv
// Boot loader: streams a length-prefixed big-endian image into blram, verifies an XOR checksum, then hands the RAM port to the CPU.
// Latency: RAM write one cycle after the 4th byte of a word; cpu_rst/done/error registered, one cycle after the deciding byte.
// Backpressure: s_ready drops for the single WRITE cycle and permanently in RUN/ERROR; s_valid may gap freely.
module ram_loader #(
    parameter int SIZE  = 14,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            reload,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            done,
    output logic            error
);
    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_WORD,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t          state_q, state_d;
    logic [SIZE-1:0] idx_q, idx_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      xor_q, xor_d;
    logic [31:0]     asm_q, asm_d;
    logic            cpu_rst_q, done_q, error_q;

    logic            xfer;
    logic [15:0]     len_new;
    logic [SIZE-1:0] idx_inc;
    logic            last_word;

    assign s_ready   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_WORD)   || (state_q == ST_CHECK);
    assign xfer      = s_valid && s_ready;
    assign len_new   = {len_q[15:8], s_data};
    assign idx_inc   = idx_q + 1'b1;
    // Index and length differ in width; compare both zero-extended to 17 bits.
    assign last_word = (17'(idx_inc) == {1'b0, len_q});

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        case (state_q)
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {s_data, 8'h00};
                    xor_d   = xor_q ^ s_data;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_new;
                    xor_d = xor_q ^ s_data;
                    if ({1'b0, len_new} > DEPTH_W) begin
                        state_d = ST_ERROR;
                    end else if (len_new == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (xfer) begin
                    asm_d      = {asm_q[23:0], s_data};
                    xor_d      = xor_q ^ s_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_d   = idx_inc;
                state_d = last_word ? ST_CHECK : ST_WORD;
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (s_data == xor_q) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_d    = ST_LEN_HI;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    xor_d      = '0;
                    asm_d      = '0;
                end
            end
            default: begin
                state_d = ST_LEN_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN_HI;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            // Flags track the state being entered so they flip on the same edge.
            cpu_rst_q  <= (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = idx_q;
        ram_data = asm_q;
        if (state_q == ST_WRITE) begin
            ram_we = 1'b1;
        end else if (state_q == ST_RUN) begin
            ram_we   = cpu_wrEn;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end
    end

    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign error   = error_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: per-cycle vector table plus a gapped-stream sequence with a write scoreboard.
module tb_ram_loader;
    localparam int SIZE = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      s_data = 8'h00;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            reload = 1'b0;
    logic            cpu_rst;
    logic            cpu_wrEn = 1'b0;
    logic [SIZE-1:0] cpu_addr = '0;
    logic [31:0]     cpu_data = '0;
    logic            ram_we;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            done;
    logic            error;

    ram_loader #(.SIZE(SIZE), .DEPTH(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .reload   (reload),
        .cpu_rst  (cpu_rst),
        .cpu_wrEn (cpu_wrEn),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic            v;
        logic [7:0]      d;
        logic            rld;
        logic            rs;
        logic            wr;
        logic [SIZE-1:0] ca;
        logic [31:0]     cd;
        logic            rdy;
        logic            we;
        logic            dn;
        logic            er;
        logic            cr;
        logic            cad;
        logic [SIZE-1:0] addr;
        logic [31:0]     data;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input string tag, input logic v, input logic [7:0] d, input logic rld,
                       input logic rs, input logic wr, input logic [SIZE-1:0] ca, input logic [31:0] cd,
                       input logic rdy, input logic we, input logic dn, input logic er, input logic cr,
                       input logic cad, input logic [SIZE-1:0] addr, input logic [31:0] data);
        vec_t x;
        x.tag = tag; x.v = v; x.d = d; x.rld = rld; x.rs = rs;
        x.wr = wr; x.ca = ca; x.cd = cd;
        x.rdy = rdy; x.we = we; x.dn = dn; x.er = er; x.cr = cr;
        x.cad = cad; x.addr = addr; x.data = data;
        tbl.push_back(x);
    endtask

    // Byte presented in a loading state (LEN_HI/LEN_LO/WORD/CHECK).
    task automatic bt(input string tag, input logic [7:0] d);
        add(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    // WRITE cycle with a byte held on s_data that must not be consumed.
    task automatic wrt(input string tag, input logic [7:0] d, input logic [SIZE-1:0] a, input logic [31:0] w);
        add(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a, w);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [7:0]      stream [11];
    logic [SIZE-1:0] wr_addr [4];
    logic [31:0]     wr_data [4];
    int              nwr;
    int              bi;
    int              cyc;
    int              held;

    initial begin
        // Nominal load
        add("rst_state", 1, 8'h00, 0, 0, 0, '0, '0, 1, 0, 0, 0, 1, 1, '0, '0);
        bt("nom_len_lo", 8'h02);
        bt("nom_b0", 8'h20); bt("nom_b1", 8'h11); bt("nom_b2", 8'h40); bt("nom_b3", 8'h45);
        wrt("nom_wr0", 8'h10, 14'd0, 32'h20114045);
        bt("nom_b4", 8'h10); bt("nom_b5", 8'h11); bt("nom_b6", 8'h40); bt("nom_b7", 8'h01);
        wrt("nom_wr1", 8'h76, 14'd1, 32'h10114001);
        bt("nom_chk", 8'h76);
        add("nom_run_cpu_wr", 0, 8'h00, 0, 0, 1, 14'd50, 32'hDEADBEEF, 0, 1, 1, 0, 0, 1, 14'd50, 32'hDEADBEEF);
        add("nom_run_cpu_rd", 1, 8'h33, 0, 0, 0, 14'd51, 32'h12345678, 0, 0, 1, 0, 0, 1, 14'd51, 32'h12345678);
        add("nom_run_reload", 0, 8'h00, 1, 0, 0, '0, '0, 0, 0, 1, 0, 0, 0, '0, '0);
        // Zero length
        bt("zl_hi", 8'h00); bt("zl_lo", 8'h00); bt("zl_chk", 8'h00);
        add("zl_run", 0, 8'h00, 0, 0, 0, 14'd7, 32'h0, 0, 0, 1, 0, 0, 1, 14'd7, 32'h0);
        add("zl_reload", 0, 8'h00, 1, 0, 0, '0, '0, 0, 0, 1, 0, 0, 0, '0, '0);
        // Bad checksum
        bt("bc_hi", 8'h00); bt("bc_lo", 8'h02);
        bt("bc_b0", 8'h20); bt("bc_b1", 8'h11); bt("bc_b2", 8'h40); bt("bc_b3", 8'h45);
        wrt("bc_wr0", 8'h10, 14'd0, 32'h20114045);
        bt("bc_b4", 8'h10); bt("bc_b5", 8'h11); bt("bc_b6", 8'h40); bt("bc_b7", 8'h01);
        wrt("bc_wr1", 8'h77, 14'd1, 32'h10114001);
        bt("bc_chk", 8'h77);
        add("bc_err", 1, 8'h55, 0, 0, 1, 14'd50, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, '0, '0);
        add("bc_err_reload", 0, 8'h00, 1, 0, 0, '0, '0, 0, 0, 0, 1, 1, 0, '0, '0);
        // Oversize length
        bt("ov_hi", 8'h04); bt("ov_lo", 8'h01);
        add("ov_err", 1, 8'h00, 0, 0, 1, 14'd3, 32'h1, 0, 0, 0, 1, 1, 0, '0, '0);
        add("ov_reload", 0, 8'h00, 1, 0, 0, '0, '0, 0, 0, 0, 1, 1, 0, '0, '0);
        // Reset mid-word, then a clean one-word image
        bt("rm_hi", 8'h00); bt("rm_lo", 8'h01); bt("rm_b0", 8'h20); bt("rm_b1", 8'h11);
        add("rm_rst", 1, 8'h40, 0, 1, 0, '0, '0, 1, 0, 0, 0, 1, 0, '0, '0);
        add("rm_reset_state", 1, 8'h00, 0, 0, 0, '0, '0, 1, 0, 0, 0, 1, 1, '0, '0);
        bt("rm2_lo", 8'h01);
        add("rm2_aa_reload_ignored", 1, 8'hAA, 1, 0, 0, '0, '0, 1, 0, 0, 0, 1, 0, '0, '0);
        bt("rm2_bb", 8'hBB); bt("rm2_cc", 8'hCC); bt("rm2_dd", 8'hDD);
        wrt("rm2_wr", 8'h01, 14'd0, 32'hAABBCCDD);
        bt("rm2_chk", 8'h01);
        add("rm2_run", 0, 8'h00, 0, 0, 0, 14'd0, 32'h0, 0, 0, 1, 0, 0, 1, 14'd0, 32'h0);

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            s_valid  = tbl[i].v;
            s_data   = tbl[i].d;
            reload   = tbl[i].rld;
            rst      = tbl[i].rs;
            cpu_wrEn = tbl[i].wr;
            cpu_addr = tbl[i].ca;
            cpu_data = tbl[i].cd;
            #1;
            total++;
            if ({s_ready, ram_we, done, error, cpu_rst} !== {tbl[i].rdy, tbl[i].we, tbl[i].dn, tbl[i].er, tbl[i].cr} ||
                (tbl[i].cad && (ram_addr !== tbl[i].addr || ram_data !== tbl[i].data))) begin
                bad++;
                $display("FAIL %s (row %0d): got rdy/we/done/err/cpu_rst=%b%b%b%b%b addr=%h data=%h, want %b%b%b%b%b addr=%h data=%h",
                         tbl[i].tag, i, s_ready, ram_we, done, error, cpu_rst, ram_addr, ram_data,
                         tbl[i].rdy, tbl[i].we, tbl[i].dn, tbl[i].er, tbl[i].cr, tbl[i].addr, tbl[i].data);
            end
        end

        // Gapped stream: s_valid toggles, but is held high through WRITE cycles.
        stream = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h40, 8'h45, 8'h10, 8'h11, 8'h40, 8'h01, 8'h76};
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; reload = 1'b0; cpu_wrEn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nwr = 0; bi = 0; cyc = 0; held = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (bi < 11) begin
                s_valid = s_ready ? cyc[0] : 1'b1;
                s_data  = stream[bi];
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (ram_we === 1'b1 && nwr < 4) begin
                wr_addr[nwr] = ram_addr;
                wr_data[nwr] = ram_data;
                nwr++;
            end
            if (s_valid && !s_ready) held++;
            if (s_valid && s_ready) bi++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        check("gap_done_reached", {31'd0, done}, 32'd1);
        check("gap_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
        check("gap_bytes_consumed", bi, 11);
        check("gap_held_in_write", held, 2);
        check("gap_write_count", nwr, 2);
        if (nwr == 2) begin
            check("gap_wr0_addr", 32'(wr_addr[0]), 32'd0);
            check("gap_wr0_data", wr_data[0], 32'h20114045);
            check("gap_wr1_addr", 32'(wr_addr[1]), 32'd1);
            check("gap_wr1_data", wr_data[1], 32'h10114001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
